score_fill_scheduler: RTL and testbench
=======================================

// Module: score_fill_scheduler
// PURPOSE
//  Sequences the NW score-matrix fill. Walks cells row-major and, per cell, issues the three
//  score-RAM reads (diag/left/up) to the read-index generator via en_read/count. It tags the
//  returning data for the cell compute unit, waits for that unit's result, then issues one write.
//  Sits between the top-level controller (start/done) and the score-RAM index/compute datapath.
// PARAMETERS
//  N        128               sequence length; fills cells (i+1,j+1) for i,j in 0..N-1
//  BitAddr  $clog2(N+1)       i/j index MSB (ports are [BitAddr:0])
//  ADDR_W   $clog2((N+1)*(N+1)-1)  write-address MSB (port is [ADDR_W:0])
//  RAM_LAT  1                 score-RAM read latency (cycles), after the registered address
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-low (0 = reset)
//  start      in   1          begin a fill; sampled in IDLE only
//  abort      in   1          synchronous abort; returns to IDLE, no done
//  calc_valid in   1          compute unit has the cell result (one-cycle pulse)
//  i, j       out  BitAddr+1  current cell indices to the read-index generator and compute unit
//  en_read    out  1          read-index generator enable
//  count      out  2          0 = diag, 1 = left, 2 = up
//  rd_valid   out  1          score-RAM data valid for the compute unit this cycle
//  rd_sel     out  2          which operand rd_valid carries (same code as count)
//  en_write   out  1          write result to the score RAM this cycle
//  wr_addr    out  ADDR_W+1   (j+1)+(N+1)*(i+1)
//  busy       out  1          high in all states except IDLE
//  done       out  1          one-cycle pulse after the last write
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. i=j=0, count=0. en_read, rd_valid, en_write, busy and done are 0.
//    rd_sel=0, wr_addr=0. Read-tag pipeline is cleared.
//  All outputs are registered.
//  FSM:
//   IDLE   -> READ when start=1. i=j=0.
//   READ   3 cycles. en_read=1, count=0,1,2 in order. -> WAIT.
//   WAIT   Waits until the third tag leaves the pipeline. -> CALC.
//   CALC   Holds i,j. -> WRITE on calc_valid. calc_valid in any other state is ignored.
//   WRITE  1 cycle. en_write=1, wr_addr valid. -> NEXT.
//   NEXT   If j<N-1: j++. Else j=0, i++.
//          If the cell just written was (N-1,N-1): -> DONE. Otherwise -> READ.
//   DONE   1 cycle. done=1. -> IDLE. i and j keep their last values until the next start.
//  Read timing: en_read/count issued in cycle t; index addr registered at t+1.
//    rd_valid=1 and rd_sel=count at t+1+RAM_LAT.
//    Implement this as a (1+RAM_LAT)-deep {valid,sel} shift pipeline.
//  count is 0 whenever en_read=0. en_read and en_write are never high in the same cycle.
//  wr_addr uses i,j widened to ADDR_W+1 bits before the multiply. No truncation for N<=128.
//  start while busy=1 is ignored. start in the DONE cycle is ignored.
//  abort=1 (any non-IDLE state) -> IDLE next cycle. Outputs go to reset values and the tag
//    pipeline is flushed. abort has priority over calc_valid and over NEXT/DONE transitions.
//  Async reset mid-fill gives the reset state immediately. No write or done may follow.
//  N=1: exactly one cell (0,0), one write at wr_addr=N+2=3, then done.
//  Per-cell cycle count (no CALC stall) = 3 READ + WAIT + 1 CALC(min) + 1 WRITE + 1 NEXT.
// TESTING
//  1 Reset: rst=0 mid-READ -> all outputs 0 same cycle. After release, IDLE with busy=0.
//  2 N=2, RAM_LAT=1, calc_valid 1 cycle after the 3rd rd_valid:
//    4 writes to wr_addr 4,5,7,8 in that order, then a single done pulse.
//  3 Read tagging: check rd_valid at 2 cycles after each en_read (rd_sel 0,1,2).
//    No rd_valid outside those cycles.
//  4 CALC stall: delay calc_valid 10 cycles -> i,j held, no en_write until the cycle after calc_valid.
//  5 abort during CALC of cell (1,0) -> IDLE next cycle, no en_write, no done.
//    A new start begins again at i=j=0.
//  6 start pulsed while busy and in the DONE cycle -> ignored. Spurious calc_valid in READ -> ignored.

Source files
------------

// File: rtl/score_fill_scheduler.sv
// Score-matrix fill sequencer: walks cells row-major, issues diag/left/up reads,
// tags returning RAM data, waits for the compute result and issues one write per cell.
module score_fill_scheduler #(
  parameter int N       = 128,
  parameter int RAM_LAT = 1,
  parameter int BitAddr = $clog2(N+1),
  parameter int ADDR_W  = $clog2((N+1)*(N+1)-1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               calc_valid_i,
  output logic [BitAddr:0]   i_o,
  output logic [BitAddr:0]   j_o,
  output logic               en_read_o,
  output logic [1:0]         count_o,
  output logic               rd_valid_o,
  output logic [1:0]         rd_sel_o,
  output logic               en_write_o,
  output logic [ADDR_W:0]    wr_addr_o,
  output logic               busy_o,
  output logic               done_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // READ   | three read requests, count 0/1/2
  // WAIT   | draining read tags until the "up" operand has been presented
  // CALC   | holding i,j until the compute unit reports its result
  // WRITE  | one-cycle score write
  // NEXT   | advance to the following cell or finish
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE, S_NEXT, S_DONE
  } state_e;

  localparam int               PIPE_D   = RAM_LAT + 1;
  localparam int               IW       = BitAddr + 1;
  localparam int               AW       = ADDR_W + 1;
  localparam logic [BitAddr:0] LAST_IDX = IW'(N - 1);
  localparam logic [BitAddr:0] IDX_ONE  = IW'(1);

  state_e state_q, state_d;

  logic [BitAddr:0] i_q, i_d, j_q, j_d;
  logic             en_read_q, en_read_d;
  logic [1:0]       count_q, count_d;
  logic             en_write_q, en_write_d;
  logic [ADDR_W:0]  wr_addr_q, wr_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Each tag stage is {valid, sel}
  logic [2:0] pipe_q [PIPE_D];
  logic [2:0] pipe_d [PIPE_D];

  logic            abort_hit;
  logic            last_cell;
  logic            tag_last;
  logic [ADDR_W:0] i_w, j_w, cell_addr;

  assign abort_hit = abort_i && (state_q != S_IDLE);
  assign last_cell = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  assign tag_last  = (pipe_q[PIPE_D-1] == 3'b110);

  assign i_w       = AW'(i_q);
  assign j_w       = AW'(j_q);
  assign cell_addr = (j_w + AW'(1)) + AW'(N + 1) * (i_w + AW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_READ;
      S_READ:  if (count_q == 2'd2) state_d = S_WAIT;
      S_WAIT:  if (tag_last) state_d = S_CALC;
      S_CALC:  if (calc_valid_i) state_d = S_WRITE;
      S_WRITE: state_d = S_NEXT;
      S_NEXT:  state_d = last_cell ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // Outputs are computed from the upcoming state so they register in step with it.
  always_comb begin
    en_read_d  = (state_d == S_READ);
    count_d    = ((state_d == S_READ) && (state_q == S_READ)) ? 2'(count_q + 2'd1) : 2'd0;
    en_write_d = (state_d == S_WRITE);
    wr_addr_d  = en_write_d ? cell_addr : '0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    i_d        = i_q;
    j_d        = j_q;
    if ((state_q == S_IDLE) && (state_d == S_READ)) begin
      i_d = '0;
      j_d = '0;
    end else if ((state_q == S_NEXT) && (state_d == S_READ)) begin
      if (j_q == LAST_IDX) begin
        j_d = '0;
        i_d = i_q + IDX_ONE;
      end else begin
        j_d = j_q + IDX_ONE;
      end
    end
    if (abort_hit) begin
      i_d = '0;
      j_d = '0;
    end

    pipe_d[0] = abort_hit ? 3'b000 : {en_read_q, count_q};
    for (int k = 1; k < PIPE_D; k++) begin
      pipe_d[k] = abort_hit ? 3'b000 : pipe_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_q        <= '0;
      j_q        <= '0;
      en_read_q  <= 1'b0;
      count_q    <= 2'd0;
      en_write_q <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < PIPE_D; k++) pipe_q[k] <= 3'b000;
    end else begin
      i_q        <= i_d;
      j_q        <= j_d;
      en_read_q  <= en_read_d;
      count_q    <= count_d;
      en_write_q <= en_write_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int k = 0; k < PIPE_D; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign i_o        = i_q;
  assign j_o        = j_q;
  assign en_read_o  = en_read_q;
  assign count_o    = count_q;
  assign rd_valid_o = pipe_q[PIPE_D-1][2];
  assign rd_sel_o   = pipe_q[PIPE_D-1][1:0];
  assign en_write_o = en_write_q;
  assign wr_addr_o  = wr_addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_score_fill_scheduler.sv
// Directed bench for score_fill_scheduler with N=2, RAM_LAT=1 (8 cycles per cell).
module tb_score_fill_scheduler;

  localparam int N = 2;
  localparam int RAM_LAT = 1;

  logic       clk_i = 1'b0;
  logic       rst_ni, start_i, abort_i, calc_valid_i;
  logic [2:0] i_o, j_o;
  logic       en_read_o, rd_valid_o, en_write_o, busy_o, done_o;
  logic [1:0] count_o, rd_sel_o;
  logic [3:0] wr_addr_o;

  int n_pass = 0;
  int n_total = 0;

  score_fill_scheduler #(.N(N), .RAM_LAT(RAM_LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .calc_valid_i(calc_valid_i), .i_o(i_o), .j_o(j_o), .en_read_o(en_read_o),
    .count_o(count_o), .rd_valid_o(rd_valid_o), .rd_sel_o(rd_sel_o),
    .en_write_o(en_write_o), .wr_addr_o(wr_addr_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // {en_read, count, rd_valid, rd_sel, en_write, busy, done}
  function automatic logic [8:0] obs_vec();
    return {en_read_o, count_o, rd_valid_o, rd_sel_o, en_write_o, busy_o, done_o};
  endfunction

  // Expected vector at cycle c (0..7) of a cell, counted from entry into READ.
  function automatic logic [8:0] exp_vec(input int c);
    logic       er, rv, ew;
    logic [1:0] cnt, rs;
    er  = (c < 3);
    cnt = er ? 2'(c) : 2'd0;
    rv  = (c >= 2) && (c <= 4);
    rs  = rv ? 2'(c - 2) : 2'd0;
    ew  = (c == 6);
    return {er, cnt, rv, rs, ew, 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    logic [18:0] all_out;
    bit          bad;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; calc_valid_i = 1'b0;
    #1;
    all_out = {obs_vec(), i_o, j_o, wr_addr_o};
    n_total++;
    if (all_out !== 19'd0) $display("FAIL reset_init: got %h expected 0", all_out);
    else n_pass++;
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    n_total++;
    if ({obs_vec(), i_o, j_o} !== 15'd0) $display("FAIL reset_idle: got %h expected 0", {obs_vec(), i_o, j_o});
    else n_pass++;
    start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i);
    n_total++;
    if (obs_vec() !== exp_vec(1)) $display("FAIL reset_pre_read: got %h expected %h", obs_vec(), exp_vec(1));
    else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    all_out = {obs_vec(), i_o, j_o, wr_addr_o};
    n_total++;
    if (all_out !== 19'd0) $display("FAIL reset_async_mid_read: got %h expected 0", all_out);
    else n_pass++;
    @(negedge clk_i); rst_ni = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (busy_o || en_write_o || done_o || en_read_o || rd_valid_o) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL reset_quiet_after: activity seen, expected none");
    else n_pass++;
  endtask

  task automatic test_fill(input bit noisy);
    logic [8:0] o;
    int ci, cj;
    start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ci = k / 2;
      cj = k % 2;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk_i);
        start_i = 1'b0;
        calc_valid_i = 1'b0;
        o = obs_vec();
        n_total++;
        if (o !== exp_vec(c)) $display("FAIL fill_cell%0d_cyc%0d: got %h expected %h", k, c, o, exp_vec(c));
        else n_pass++;
        if (c == 0 || c == 5) begin
          n_total++;
          if ({i_o, j_o} !== {3'(ci), 3'(cj)})
            $display("FAIL fill_ij_cell%0d: got i=%0d j=%0d expected i=%0d j=%0d", k, i_o, j_o, ci, cj);
          else n_pass++;
        end
        if (c == 6) begin
          n_total++;
          if (wr_addr_o !== 4'((cj + 1) + (N + 1) * (ci + 1)))
            $display("FAIL fill_wr_addr_cell%0d: got %0d expected %0d", k, wr_addr_o, (cj + 1) + (N + 1) * (ci + 1));
          else n_pass++;
        end
        if (c == 5) calc_valid_i = 1'b1;
        if (noisy && k == 0 && c == 1) calc_valid_i = 1'b1;
        if (noisy && k == 1 && c == 3) start_i = 1'b1;
      end
    end
    @(negedge clk_i);
    n_total++;
    if (obs_vec() !== 9'b0_00_0_00_0_1_1) $display("FAIL fill_done_pulse: got %h expected %h", obs_vec(), 9'b0_00_0_00_0_1_1);
    else n_pass++;
    if (noisy) start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n_total++;
    if (obs_vec() !== 9'd0) $display("FAIL fill_idle_after_done: got %h expected 0", obs_vec());
    else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (obs_vec() !== 9'd0) $display("FAIL fill_stays_idle: got %h expected 0", obs_vec());
    else n_pass++;
  endtask

  task automatic test_calc_stall();
    bit bad;
    start_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    n_total++;
    if (obs_vec() !== exp_vec(5)) $display("FAIL stall_enter_calc: got %h expected %h", obs_vec(), exp_vec(5));
    else n_pass++;
    bad = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk_i);
      if ({en_write_o, en_read_o, rd_valid_o, busy_o, i_o, j_o} !== {4'b0001, 6'd0}) bad = 1'b1;
      if (s == 10) calc_valid_i = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL stall_hold: state changed during stall, expected i,j held and no write");
    else n_pass++;
    @(negedge clk_i);
    calc_valid_i = 1'b0;
    n_total++;
    if ({en_write_o, wr_addr_o} !== {1'b1, 4'd4}) $display("FAIL stall_write: got en=%b addr=%0d expected en=1 addr=4", en_write_o, wr_addr_o);
    else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (obs_vec() !== exp_vec(7)) $display("FAIL stall_next: got %h expected %h", obs_vec(), exp_vec(7));
    else n_pass++;
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    n_total++;
    if ({obs_vec(), i_o, j_o} !== 15'd0) $display("FAIL stall_abort_in_next: got %h expected 0", {obs_vec(), i_o, j_o});
    else n_pass++;
  endtask

  task automatic test_abort();
    bit bad;
    start_i = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      calc_valid_i = (cyc == 5) || (cyc == 13);
    end
    n_total++;
    if ({obs_vec(), i_o, j_o} !== {exp_vec(5), 3'd1, 3'd0})
      $display("FAIL abort_at_calc_10: got %h expected %h", {obs_vec(), i_o, j_o}, {exp_vec(5), 3'd1, 3'd0});
    else n_pass++;
    abort_i = 1'b1;
    calc_valid_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    calc_valid_i = 1'b0;
    n_total++;
    if ({obs_vec(), i_o, j_o, wr_addr_o} !== 19'd0)
      $display("FAIL abort_outputs: got %h expected 0", {obs_vec(), i_o, j_o, wr_addr_o});
    else n_pass++;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (en_write_o || done_o || busy_o || rd_valid_o) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL abort_quiet: activity after abort, expected none");
    else n_pass++;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n_total++;
    if ({en_read_o, count_o, i_o, j_o} !== {1'b1, 2'd0, 6'd0})
      $display("FAIL abort_restart: got %h expected %h", {en_read_o, count_o, i_o, j_o}, {1'b1, 2'd0, 6'd0});
    else n_pass++;
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    n_total++;
    if (obs_vec() !== 9'd0) $display("FAIL abort_in_read: got %h expected 0", obs_vec());
    else n_pass++;
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_fill(1'b0);
    test_calc_stall();
    test_abort();
    test_fill(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
